reglk_ctrl_seq: RTL



---
 rtl/reglk_pkg.sv | 29 ++
 rtl/reglk_ctrl_seq_if.sv | 27 ++
 rtl/reglk_ctrl_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/reglk_pkg.sv
// Shared definitions for the reglk boot sequencer: FSM states, default
// geometry and the word-index to byte-address helper.
package reglk_pkg;

  // Six 32-bit lock words: the SoC has NB_PERIPHERALS lock bytes (8 bits
  // per peripheral), packed four to a word.
  localparam int NB_WORDS_DEF = 6;

  // Index of the virtual seal register; never forwarded to the bus.
  localparam int SEAL_IDX_DEF = 7;

  // Width of a software word index.
  localparam int IDX_W = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BOOT_WR = 3'd1,
    BOOT_RD = 3'd2,
    RUN     = 3'd3,
    SW_ACC  = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Byte address of a 32-bit word on the 8-bit peripheral register bus.
  function automatic logic [7:0] idx_to_addr(input logic [IDX_W-1:0] idx);
    return {1'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/reglk_ctrl_seq_if.sv
// Peripheral register bus between the sequencer (master) and the reglk
// register block (slave).
//
// Handshake: the master raises reg_valid_o with reg_write_o, reg_addr_o and
// reg_wdata_o and holds all of them stable until a cycle in which the slave
// drives reg_ready_i=1; that cycle completes the access, and reg_rdata_i and
// reg_error_i are only meaningful in it. The slave may hold reg_ready_i low
// for any number of cycles to stretch an access.
interface reglk_ctrl_seq_if;
  logic        reg_valid_o;
  logic        reg_write_o;
  logic [7:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [31:0] reg_rdata_i;
  logic        reg_ready_i;
  logic        reg_error_i;

  modport master (
    output reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o,
    input  reg_rdata_i, reg_ready_i, reg_error_i
  );

  modport slave (
    input  reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o,
    output reg_rdata_i, reg_ready_i, reg_error_i
  );
endinterface

// File: rtl/reglk_ctrl_seq.sv
// reglk boot sequencer and bus master. After reset it writes the lock image
// into the reglk words, reads it back to verify, then forwards software
// accesses. A software seal blocks further lock writes until reset.
module reglk_ctrl_seq
  import reglk_pkg::*;
#(
  parameter int NB_WORDS = NB_WORDS_DEF,
  parameter int SEAL_IDX = SEAL_IDX_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [32*NB_WORDS-1:0]   boot_cfg_i,
  // software config port
  input  logic                     sw_req_i,
  input  logic                     sw_we_i,
  input  logic [IDX_W-1:0]         sw_idx_i,
  input  logic [31:0]              sw_wdata_i,
  output logic                     sw_ack_o,
  output logic [31:0]              sw_rdata_o,
  output logic                     sw_err_o,
  // peripheral register bus
  reglk_ctrl_seq_if.master         bus,
  // status
  output logic                     boot_done_o,
  output logic                     boot_err_o,
  output logic                     sealed_o,
  output state_t                   dbg_state_o
);

  localparam logic [IDX_W-1:0] NB_IDX   = IDX_W'(NB_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_WORDS - 1);
  localparam logic [IDX_W-1:0] SEAL_I   = IDX_W'(SEAL_IDX);

  // Registered state
  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              r_sealed;
  logic              r_boot_err;

  // Next-state values
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_we_nxt;
  logic [31:0]       w_wdata_nxt;
  logic [31:0]       w_rdata_nxt;
  logic              w_err_nxt;
  logic              w_sealed_nxt;
  logic              w_boot_err_nxt;

  logic [31:0]       w_boot_word;
  logic              w_rd_bad;
  logic              w_done_acc;

  // Boot image word selected by the current index (only used while idx is
  // inside the image).
  always_comb begin
    w_boot_word = '0;
    for (int i = 0; i < NB_WORDS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_boot_word = boot_cfg_i[i*32 +: 32];
      end
    end
  end

  // An access finishes in any bus state when the slave signals ready.
  assign w_done_acc = bus.reg_ready_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_we_nxt       = r_we;
    w_wdata_nxt    = r_wdata;
    w_rdata_nxt    = r_rdata;
    w_err_nxt      = r_err;
    w_sealed_nxt   = r_sealed;
    w_boot_err_nxt = r_boot_err;
    w_rd_bad       = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_idx_nxt   = '0;
        w_state_nxt = BOOT_WR;
      end

      BOOT_WR: begin
        if (w_done_acc) begin
          w_boot_err_nxt = r_boot_err | bus.reg_error_i;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = BOOT_RD;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end

      BOOT_RD: begin
        if (w_done_acc) begin
          w_rd_bad       = (bus.reg_rdata_i != w_boot_word) | bus.reg_error_i;
          w_boot_err_nxt = r_boot_err | w_rd_bad;
          if (r_idx == LAST_IDX) begin
            // A failed boot leaves the lock image untrusted: seal it.
            w_sealed_nxt = r_sealed | r_boot_err | w_rd_bad;
            w_idx_nxt    = '0;
            w_state_nxt  = RUN;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end

      RUN: begin
        if (sw_req_i) begin
          w_idx_nxt   = sw_idx_i;
          w_we_nxt    = sw_we_i;
          w_wdata_nxt = sw_wdata_i;
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b0;
          if (sw_idx_i < NB_IDX) begin
            if (!sw_we_i || !r_sealed) begin
              w_state_nxt = SW_ACC;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = DONE;
            end
          end else if (sw_idx_i == SEAL_I) begin
            if (sw_we_i) begin
              w_sealed_nxt = r_sealed | sw_wdata_i[0];
            end else begin
              w_rdata_nxt = {31'b0, r_sealed};
            end
            w_state_nxt = DONE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end

      SW_ACC: begin
        if (w_done_acc) begin
          w_rdata_nxt = r_we ? 32'h0 : bus.reg_rdata_i;
          w_err_nxt   = bus.reg_error_i;
          w_state_nxt = DONE;
        end
      end

      DONE: begin
        w_state_nxt = RUN;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers: index, latched request, response and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_sealed   <= 1'b0;
      r_boot_err <= 1'b0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_we       <= w_we_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rdata    <= w_rdata_nxt;
      r_err      <= w_err_nxt;
      r_sealed   <= w_sealed_nxt;
      r_boot_err <= w_boot_err_nxt;
    end
  end

  // Bus write data: boot word during boot writes, latched data for software
  // writes, zero otherwise.
  always_comb begin
    bus.reg_wdata_o = '0;
    if (r_state == BOOT_WR) begin
      bus.reg_wdata_o = w_boot_word;
    end else if (r_state == SW_ACC && r_we) begin
      bus.reg_wdata_o = r_wdata;
    end
  end

  // Remaining outputs decode straight from flops.
  assign bus.reg_valid_o = (r_state == BOOT_WR) || (r_state == BOOT_RD) ||
                           (r_state == SW_ACC);
  assign bus.reg_write_o = (r_state == BOOT_WR) || ((r_state == SW_ACC) && r_we);
  assign bus.reg_addr_o  = idx_to_addr(r_idx);

  assign sw_ack_o    = (r_state == DONE);
  assign sw_rdata_o  = r_rdata;
  assign sw_err_o    = r_err;
  assign boot_done_o = (r_state == RUN) || (r_state == SW_ACC) || (r_state == DONE);
  assign boot_err_o  = r_boot_err;
  assign sealed_o    = r_sealed;
  assign dbg_state_o = r_state;

endmodule
